// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial 32-bit a - b - bin, LSB first, one bit per clock; optional saturation via SERIAL_SUB_SATURATE_EN
module serial_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        bout,
  output logic        of
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_a, r_b, r_diff;
  logic [30:0] r_d;
  logic [4:0]  r_cnt;
  logic        r_c, r_bout, r_of;
  logic        w_s, w_co, w_last;
  logic [31:0] w_res, w_diff;
  assign w_s    = r_a[0] ^ ~r_b[0] ^ r_c;
  assign w_co   = (r_a[0] & ~r_b[0]) | (r_c & (r_a[0] ^ ~r_b[0]));
  assign w_last = r_cnt == 5'd31;
  assign w_res  = {w_s, r_d};
`ifdef SERIAL_SUB_SATURATE_EN
  // on the final bit r_a[0] holds the original sign of a, which picks the clamp direction
  assign w_diff = (r_c ^ w_co) ? (r_a[0] ? 32'h8000_0000 : 32'h7FFF_FFFF) : w_res;
`else
  assign w_diff = w_res;
`endif
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  assign diff = r_diff;
  assign bout = r_bout;
  assign of   = r_of;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // IDLE waits for start, RUN lasts 32 bits, DONE is a single-cycle publish
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  // operand shift registers, ripple borrow chain and result publish on the last bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_of   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a   <= a;
      r_b   <= b;
      r_c   <= ~bin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= {1'b0, r_a[31:1]};
      r_b   <= {1'b0, r_b[31:1]};
      r_d   <= w_res[31:1];
      r_c   <= w_co;
      r_cnt <= r_cnt + 5'd1;
      if (w_last) begin
        r_diff <= w_diff;
        r_bout <= ~w_co;
        r_of   <= r_c ^ w_co;
      end
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: a  input  32  minuend, two's complement; sampled with start.
REQ-006 Port: b  input  32  subtrahend, two's complement; sampled with start.
REQ-007 Port: bin  input  1  borrow-in; sampled with start.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle pulse when a result is published.
REQ-010 Port: diff  output  32  result, a - b - bin mod 2^32.
REQ-011 Port: bout  output  1  borrow-out; high when unsigned a < b + bin.
REQ-012 Port: of  output  1  signed overflow of the subtraction.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL latch a, b and bin, clear the bit counter, and enter RUN.
REQ-015 In RUN, each edge SHALL process one bit, LSB first: d_i = a_i XOR ~b_i XOR c_i, with c_0 = ~bin and c_(i+1) = carry of a_i + ~b_i + c_i.
REQ-016 RUN SHALL last exactly 32 edges; the 32nd edge SHALL enter DONE and load diff, bout and of together.
REQ-017 Latency: if start is accepted at edge N, done SHALL be high for the cycle between edges N+32 and N+33.
REQ-018 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-019 bout SHALL equal ~c_32.
REQ-020 of SHALL equal c_31 XOR c_32.
REQ-021 diff, bout and of SHALL hold their last published value through IDLE and RUN; partial results SHALL never appear on them.
REQ-022 start SHALL be ignored in RUN and in DONE; a and b changing during RUN SHALL have no effect.
REQ-023 start held high continuously SHALL cause back-to-back operations, one every 34 cycles.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, busy=0, done=0, diff=0, bout=0, of=0, and clear the internal shift registers and counter.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL accept a new start from IDLE.

Configuration
REQ-026 Macro SERIAL_SUB_SATURATE_EN defined: when of=1, diff SHALL be 0x7FFFFFFF if a[31]=0 and 0x80000000 if a[31]=1; bout and of are unchanged.
REQ-027 Macro SERIAL_SUB_SATURATE_EN undefined: diff SHALL always be the wrapped result.

Verification
REQ-028 a=0x7FFFFFFF, b=0xFFFFFFFF, bin=0 -> diff=0x80000000 (0x7FFFFFFF with SATURATE), bout=1, of=1, done exactly 32 edges after the start edge.
REQ-029 a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF (0x80000000 with SATURATE), bout=0, of=1.
REQ-030 a=0x2468ACE9, b=0x12345678, bin=1 -> diff=0x12345670, bout=0, of=0.
REQ-031 a=0x00000000, b=0x00000000, bin=1 -> diff=0xFFFFFFFF, bout=1, of=0; then pulse start and change a during RUN -> start ignored and result unchanged.
REQ-032 rst_n low at RUN bit 10 -> all outputs 0, no done pulse; a following operation a=0x420, b=0x20, bin=0 -> diff=0x400, bout=0, of=0.
